// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_pkg: shared types and glyph constants for the seven-segment
// scan decoder.
//   scan_state_t : capture FSM states (WAIT, SETTLING, HELD)
//   glyph_t      : decoded digit {err, blank, nibble}
//   SEG_0..SEG_F : segment patterns, bit order {a,b,c,d,e,f,g} = [6:0]
//   SEG_BLANK    : all segments off
//   is_onehot()  : true when exactly one bit of a digit select is set
package seg_scan_pkg;

    typedef enum logic [1:0] {
        WAIT     = 2'd0,
        SETTLING = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic       err;
        logic       blank;
        logic [3:0] nibble;
    } glyph_t;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != '0) && ((v & (v - 8'd1)) == '0);
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: multiplexed seven-segment display scan bus.
//   DIGIT[7:0] : digit select, active-high, one-hot (bit i = position i)
//   SEG[6:0]   : segments, active-high, {a,b,c,d,e,f,g}
// master = display driver, slave = scan decoder.
interface seg_scan_decoder_if;
    logic [7:0] DIGIT;
    logic [6:0] SEG;

    modport master (output DIGIT, SEG);
    modport slave  (input  DIGIT, SEG);
endinterface

// File: rtl/seg_scan_decoder_glyph.sv
// seg7_glyph_decode: combinational seven-segment pattern decoder.
//   seg   : segment pattern {a,b,c,d,e,f,g}
//   glyph : {err, blank, nibble}; hex glyphs give their nibble, all-off
//           gives blank, anything else gives err. nibble is 0 unless a
//           hex glyph matched.
module seg7_glyph_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg,
    output glyph_t     glyph
);

    always_comb begin
        glyph = '0;
        case (seg)
            SEG_0:     glyph.nibble = 4'h0;
            SEG_1:     glyph.nibble = 4'h1;
            SEG_2:     glyph.nibble = 4'h2;
            SEG_3:     glyph.nibble = 4'h3;
            SEG_4:     glyph.nibble = 4'h4;
            SEG_5:     glyph.nibble = 4'h5;
            SEG_6:     glyph.nibble = 4'h6;
            SEG_7:     glyph.nibble = 4'h7;
            SEG_8:     glyph.nibble = 4'h8;
            SEG_9:     glyph.nibble = 4'h9;
            SEG_A:     glyph.nibble = 4'hA;
            SEG_B:     glyph.nibble = 4'hB;
            SEG_C:     glyph.nibble = 4'hC;
            SEG_D:     glyph.nibble = 4'hD;
            SEG_E:     glyph.nibble = 4'hE;
            SEG_F:     glyph.nibble = 4'hF;
            SEG_BLANK: glyph.blank  = 1'b1;
            default:   glyph.err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reconstructs eight displayed characters from a
// multiplexed seven-segment scan bus.
//   clk         : system clock
//   rst         : synchronous reset, active-low
//   scan        : seg_scan_decoder_if.slave (DIGIT, SEG)
//   value       : decoded nibbles, position i at value[4i+3:4i]
//   blank/err   : per-position all-off / non-hex-glyph flags
//   frame_valid : one-cycle pulse when value/blank/err update
//   frame_err   : sticky, set by a multi-bit DIGIT select
//   stale       : frame watchdog expired (only with SEG_SCAN_TIMEOUT_EN)
// Optional feature macro: SEG_SCAN_TIMEOUT_EN (adds TIMEOUT and stale).
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int SETTLE = 4
`ifdef SEG_SCAN_TIMEOUT_EN
  , parameter int TIMEOUT = 1_000_000
`endif
) (
    input  logic                clk,
    input  logic                rst,
    seg_scan_decoder_if.slave   scan,
    output logic [31:0]         value,
    output logic [7:0]          blank,
    output logic [7:0]          err,
    output logic                frame_valid,
    output logic                frame_err
`ifdef SEG_SCAN_TIMEOUT_EN
  , output logic                stale
`endif
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    scan_state_t state_q, state_d;
    logic [7:0]  s_dig_q, p_dig_q, stab_q, stab_d, seen_q, seen_d;
    logic [6:0]  s_seg_q, p_seg_q;
    glyph_t [7:0] shadow_q, shadow_d;
    logic [31:0] value_q, value_d;
    logic [7:0]  blank_q, blank_d, err_q, err_d;
    logic        frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;

    logic        same, dig_onehot, dig_zero, capture, illegal_sel, complete;
    logic [2:0]  cap_pos;
    glyph_t      cap_glyph;

    assign same       = (s_dig_q == p_dig_q) && (s_seg_q == p_seg_q);
    assign dig_onehot = is_onehot(s_dig_q);
    assign dig_zero   = (s_dig_q == '0);
    assign complete   = (seen_q == '1);

    seg7_glyph_decode u_glyph (
        .seg   (s_seg_q),
        .glyph (cap_glyph)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= WAIT;
        else      state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (!dig_onehot) begin
            state_d = WAIT;
        end else begin
            case (state_q)
                WAIT:     state_d = SETTLING;
                SETTLING: if (same && stab_q == SETTLE_C) state_d = HELD;
                HELD:     if (!same) state_d = SETTLING;
                default:  state_d = WAIT;
            endcase
        end
    end

    // FSM: outputs. stab_q == SETTLE with an unchanged sample means the
    // pattern has been identical for SETTLE+1 registered samples.
    always_comb begin
        capture     = (state_q == SETTLING) && dig_onehot && same && (stab_q == SETTLE_C);
        illegal_sel = !dig_zero && !dig_onehot;
    end

    always_comb begin
        cap_pos = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (s_dig_q[i]) cap_pos = 3'(i);
        end
    end

    // Datapath. The frame copy reads shadow_q, so a capture landing on the
    // copy edge is kept for the next frame via seen_d.
    always_comb begin
        stab_d        = same ? ((stab_q == SETTLE_C) ? stab_q : stab_q + 8'd1) : 8'd1;
        seen_d        = complete ? '0 : seen_q;
        shadow_d      = shadow_q;
        value_d       = value_q;
        blank_d       = blank_q;
        err_d         = err_q;
        frame_valid_d = complete;
        frame_err_d   = frame_err_q | illegal_sel;
        if (capture) begin
            seen_d[cap_pos]   = 1'b1;
            shadow_d[cap_pos] = cap_glyph;
        end
        if (complete) begin
            for (int unsigned i = 0; i < 8; i++) begin
                value_d[4*i +: 4] = shadow_q[i].nibble;
                blank_d[i]        = shadow_q[i].blank;
                err_d[i]          = shadow_q[i].err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_dig_q       <= '0;
            s_seg_q       <= '0;
            p_dig_q       <= '0;
            p_seg_q       <= '0;
            stab_q        <= '0;
            seen_q        <= '0;
            shadow_q      <= '0;
            value_q       <= '0;
            blank_q       <= '1;
            err_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            s_dig_q       <= scan.DIGIT;
            s_seg_q       <= scan.SEG;
            p_dig_q       <= s_dig_q;
            p_seg_q       <= s_seg_q;
            stab_q        <= stab_d;
            seen_q        <= seen_d;
            shadow_q      <= shadow_d;
            value_q       <= value_d;
            blank_q       <= blank_d;
            err_q         <= err_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign value       = value_q;
    assign blank       = blank_q;
    assign err         = err_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

`ifdef SEG_SCAN_TIMEOUT_EN
    localparam logic [19:0] TIMEOUT_C = 20'(TIMEOUT);

    logic [19:0] to_cnt_q, to_cnt_d;
    logic        stale_q, stale_d;

    // Counter saturates at TIMEOUT so stale cannot drop by wrap-around.
    always_comb begin
        to_cnt_d = to_cnt_q;
        stale_d  = stale_q;
        if (complete) begin
            to_cnt_d = '0;
            stale_d  = 1'b0;
        end else begin
            if (to_cnt_q != TIMEOUT_C) to_cnt_d = to_cnt_q + 20'd1;
            if (to_cnt_d == TIMEOUT_C) stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q <= '0;
            stale_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            stale_q  <= stale_d;
        end
    end

    assign stale = stale_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
`timescale 1ns/1ps
module tb_seg_scan_decoder;

    localparam int SETTLE = 4;
`ifdef SEG_SCAN_TIMEOUT_EN
    localparam int TIMEOUT = 100;
`endif

    typedef struct packed { logic [31:0] v; logic [7:0] b; logic [7:0] e; } frame_t;
    typedef struct { logic [6:0] seg; logic [3:0] nib; logic blank; logic err; } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] value;
    logic [7:0]  blank, err;
    logic        frame_valid, frame_err;
`ifdef SEG_SCAN_TIMEOUT_EN
    logic        stale;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    frame_t obs_q[$];
    frame_t exp_q[$];

    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    vec_t tab [24] = '{
        '{7'h7E, 4'h0, 1'b0, 1'b0}, '{7'h30, 4'h1, 1'b0, 1'b0},
        '{7'h6D, 4'h2, 1'b0, 1'b0}, '{7'h79, 4'h3, 1'b0, 1'b0},
        '{7'h33, 4'h4, 1'b0, 1'b0}, '{7'h5B, 4'h5, 1'b0, 1'b0},
        '{7'h5F, 4'h6, 1'b0, 1'b0}, '{7'h70, 4'h7, 1'b0, 1'b0},
        '{7'h7F, 4'h8, 1'b0, 1'b0}, '{7'h7B, 4'h9, 1'b0, 1'b0},
        '{7'h77, 4'hA, 1'b0, 1'b0}, '{7'h1F, 4'hB, 1'b0, 1'b0},
        '{7'h4E, 4'hC, 1'b0, 1'b0}, '{7'h3D, 4'hD, 1'b0, 1'b0},
        '{7'h4F, 4'hE, 1'b0, 1'b0}, '{7'h47, 4'hF, 1'b0, 1'b0},
        '{7'h00, 4'h0, 1'b1, 1'b0}, '{7'h3F, 4'h0, 1'b0, 1'b1},
        '{7'h40, 4'h0, 1'b0, 1'b1}, '{7'h08, 4'h0, 1'b0, 1'b1},
        '{7'h01, 4'h0, 1'b0, 1'b1}, '{7'h7C, 4'h0, 1'b0, 1'b1},
        '{7'h49, 4'h0, 1'b0, 1'b1}, '{7'h00, 4'h0, 1'b1, 1'b0}
    };

    always #5 clk = ~clk;

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(
        .SETTLE(SETTLE)
`ifdef SEG_SCAN_TIMEOUT_EN
      , .TIMEOUT(TIMEOUT)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .scan(bus),
        .value(value),
        .blank(blank),
        .err(err),
        .frame_valid(frame_valid),
        .frame_err(frame_err)
`ifdef SEG_SCAN_TIMEOUT_EN
      , .stale(stale)
`endif
    );

    always @(negedge clk) begin
        if (frame_valid === 1'b1) obs_q.push_back({value, blank, err});
    end

    // ---------------- reference model ----------------
    // A run of identical (DIGIT,SEG) lasting at least SETTLE+1 cycles with a
    // one-hot DIGIT captures once; eight distinct positions make a frame.
    logic [3:0] m_nib [8];
    logic [7:0] m_blank, m_err, m_seen, m_ld;
    logic [6:0] m_ls;
    logic       m_ferr;
    int         m_run;
    bit         m_done;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
        m_blank = '0; m_err = '0; m_seen = '0; m_ferr = 1'b0;
        m_ld = '0; m_ls = '0; m_run = 1000; m_done = 1'b1;
        exp_q.delete();
    endfunction

    function automatic void model_step(input logic [7:0] d, input logic [6:0] s, input int n);
        int pos;
        frame_t f;
        if (d == m_ld && s == m_ls) m_run += n;
        else begin m_run = n; m_done = 1'b0; end
        m_ld = d; m_ls = s;
        if ($countones(d) > 1) m_ferr = 1'b1;
        if ($countones(d) == 1 && !m_done && m_run >= SETTLE + 1) begin
            m_done = 1'b1;
            pos = $clog2(d);
            m_nib[pos] = 4'h0; m_blank[pos] = 1'b0; m_err[pos] = 1'b1;
            if (s == 7'h00) begin m_blank[pos] = 1'b1; m_err[pos] = 1'b0; end
            for (int g = 0; g < 16; g++)
                if (glyph[g] == s) begin m_nib[pos] = 4'(g); m_err[pos] = 1'b0; end
            m_seen[pos] = 1'b1;
            if (m_seen == 8'hFF) begin
                for (int i = 0; i < 8; i++) f.v[4*i +: 4] = m_nib[i];
                f.b = m_blank; f.e = m_err;
                exp_q.push_back(f);
                m_seen = '0;
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic [6:0] s, input int n);
        bus.DIGIT = d;
        bus.SEG   = s;
        model_step(d, s, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.DIGIT = '0;
        bus.SEG   = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        obs_q.delete();
    endtask

    task automatic compare_model(input string name);
        int n;
        check({name, " model frames"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({name, " model frame"}, 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic expect_frame(input string name, input logic [31:0] v,
                                input logic [7:0] b, input logic [7:0] e);
        drive(8'h00, 7'h00, 8);
        check({name, " pulses"}, 64'(obs_q.size()), 64'd1);
        if (obs_q.size() > 0) begin
            check({name, " value"}, 64'(obs_q[0].v), 64'(v));
            check({name, " blank"}, 64'(obs_q[0].b), 64'(b));
            check({name, " err"},   64'(obs_q[0].e), 64'(e));
        end
        compare_model(name);
    endtask

    task automatic scan_all(input logic [6:0] s, input int dwell);
        for (int i = 0; i < 8; i++) drive(8'h01 << i, s, dwell);
    endtask

    // ---------------- stimulus ----------------
    logic [6:0] plan [8] = '{7'h7E, 7'h30, 7'h5B, 7'h7F, 7'h00, 7'h7E, 7'h7E, 7'h7E};

    initial begin
        logic [7:0] d;
        logic [6:0] s;
        int         pos;

        bus.DIGIT = '0;
        bus.SEG   = '0;
        model_reset();
        do_reset();
        check("rst value",       64'(value),       64'h0);
        check("rst blank",       64'(blank),       64'hFF);
        check("rst err",         64'(err),         64'h0);
        check("rst frame_valid", 64'(frame_valid), 64'h0);
        check("rst frame_err",   64'(frame_err),   64'h0);

        // Decode table: three frames of eight table entries each.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) drive(8'h01 << i, tab[8*f+i].seg, 6);
            drive(8'h00, 7'h00, 8);
            check("table pulses", 64'(obs_q.size()), 64'd1);
            if (obs_q.size() > 0)
                for (int i = 0; i < 8; i++)
                    check($sformatf("table entry %0d", 8*f+i),
                          64'({obs_q[0].v[4*i +: 4], obs_q[0].b[i], obs_q[0].e[i]}),
                          64'({tab[8*f+i].nib, tab[8*f+i].blank, tab[8*f+i].err}));
            compare_model("table");
        end

        // Basic scan example.
        for (int i = 0; i < 8; i++) drive(8'h01 << i, plan[i], 6);
        expect_frame("plan scan", 32'h0000_8510, 8'h10, 8'h00);

        // Glitch before settle, and a revisit before completion: last wins.
        drive(8'h01, 7'h7E, 6);
        drive(8'h02, 7'h30, 6);
        drive(8'h04, 7'h30, 2);
        drive(8'h04, 7'h5B, 6);
        drive(8'h08, 7'h79, 6);
        drive(8'h10, 7'h33, 6);
        drive(8'h20, 7'h6D, 6);
        drive(8'h02, 7'h7F, 6);
        drive(8'h40, 7'h70, 6);
        drive(8'h80, 7'h7B, 6);
        expect_frame("recapture", 32'h9724_3580, 8'h00, 8'h00);

        // Illegal select mid-frame: sticky frame_err, frame still completes.
        drive(8'h01, 7'h4F, 6);
        drive(8'h02, 7'h47, 6);
        drive(8'h04, 7'h77, 6);
        drive(8'h08, 7'h1F, 6);
        drive(8'h03, 7'h7E, 1);
        drive(8'h10, 7'h4E, 6);
        check("frame_err set", 64'(frame_err), 64'h1);
        drive(8'h20, 7'h3D, 6);
        drive(8'h40, 7'h5F, 6);
        drive(8'h80, 7'h7B, 6);
        expect_frame("illegal sel", 32'h96DC_BAFE, 8'h00, 8'h00);
        check("frame_err sticky", 64'(frame_err), 64'h1);

        // Dwell boundary: SETTLE cycles is too short, SETTLE+1 captures.
        for (int i = 0; i < 8; i++) drive(8'h01 << i, 7'h5F, (i == 3) ? SETTLE : 6);
        drive(8'h00, 7'h00, 20);
        check("short dwell pulses", 64'(obs_q.size()), 64'd0);
        compare_model("short dwell");
        drive(8'h08, 7'h5F, SETTLE + 1);
        expect_frame("min dwell", 32'h6666_6666, 8'h00, 8'h00);

        // Reset mid-frame discards captured positions.
        for (int i = 0; i < 5; i++) drive(8'h01 << i, 7'h30, 6);
        do_reset();
        check("rst clears frame_err", 64'(frame_err), 64'h0);
        for (int i = 5; i < 8; i++) drive(8'h01 << i, 7'h6D, 6);
        drive(8'h00, 7'h00, 8);
        check("rst partial pulses", 64'(obs_q.size()), 64'd0);
        for (int i = 0; i < 5; i++) drive(8'h01 << i, 7'h6D, 6);
        expect_frame("post rst", 32'h2222_2222, 8'h00, 8'h00);

`ifdef SEG_SCAN_TIMEOUT_EN
        do_reset();
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        check("stale before timeout", 64'(stale), 64'h0);
        @(posedge clk);
        #1;
        check("stale at timeout", 64'(stale), 64'h1);
        scan_all(7'h7E, 6);
        expect_frame("stale clear frame", 32'h0, 8'h00, 8'h00);
        check("stale cleared", 64'(stale), 64'h0);
`endif

        // Randomised scan against the model.
        do_reset();
        pos = 0;
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 19))
                0, 1, 2:  d = 8'h00;
                3:        d = (8'h01 << 3'($urandom_range(0, 7))) | (8'h01 << 3'($urandom_range(0, 7)));
                default: begin
                    d = 8'h01 << pos[2:0];
                    if ($urandom_range(0, 3) != 0) pos = (pos + 1) % 8;
                end
            endcase
            case ($urandom_range(0, 9))
                7:       s = 7'h00;
                8, 9:    s = 7'($urandom);
                default: s = glyph[$urandom_range(0, 15)];
            endcase
            drive(d, s, $urandom_range(1, 8));
        end
        drive(8'h00, 7'h00, 8);
        check("random frame_err", 64'(frame_err), 64'(m_ferr));
        compare_model("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
